stim_vector_sequencer: RTL and testbench

- Upstream stimulus stage for the sensitivity/indexing checker, which consumes a 15-bit data vector and a 4-bit index.
- Generates a bounded burst of pseudo-random data words from a Galois LFSR, paired with a walking index that wraps before it can overrun a 2-bit part-select.
- Provides start/stall control, registered outputs, and a one-cycle done pulse, so downstream always/sensitivity tests get deterministic, repeatable input sequences.

---
 rtl/stim_vector_sequencer.sv | 110 +++++++++++
 tb/tb_stim_vector_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stim_vector_sequencer.sv
// Stimulus sequencer: emits a bounded burst of Galois-LFSR data words paired with a
// wrapping index, with start/stall control, registered outputs and a one-cycle done pulse.
module stim_vector_sequencer #(
    parameter int unsigned        DATA_W    = 15,
    parameter int unsigned        IDX_W     = 4,
    parameter int unsigned        NUM_STEPS = 16,
    parameter int unsigned        IDX_LIMIT = 13,
    parameter logic [DATA_W-1:0]  SEED      = 15'h0001,
    parameter logic [DATA_W-1:0]  TAPS      = 15'h6000,
    parameter int unsigned        CNT_W     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    output logic [DATA_W-1:0] data_out,
    output logic [IDX_W-1:0]  idx_out,
    output logic              valid,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  step_count
);

    typedef enum logic [1:0] {StIdle, StRun, StHold, StDone} state_e;

    // An all-zero seed would lock the LFSR at zero, so it is replaced by 1.
    localparam logic [DATA_W-1:0] SeedEff  = (SEED == '0) ? DATA_W'(1) : SEED;
    localparam logic [CNT_W-1:0]  LastStep = CNT_W'(NUM_STEPS);
    localparam logic [IDX_W-1:0]  IdxLast  = IDX_W'(IDX_LIMIT);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;

    logic [DATA_W-1:0]   lfsr_next;
    logic [IDX_W-1:0]    idx_next;

    assign lfsr_next = (data_q >> 1) ^ (data_q[0] ? TAPS : '0);
    assign idx_next  = (idx_q == IdxLast) ? '0 : idx_q + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    data_d  = SeedEff;
                    idx_d   = '0;
                    cnt_d   = CNT_W'(1);
                    valid_d = 1'b1;
                end
            end
            StRun, StHold: begin
                // A stalled vector still counts as delivered; it is never re-presented.
                if (stall) begin
                    state_d = StHold;
                end else if (cnt_q == LastStep) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    state_d = StRun;
                    data_d  = lfsr_next;
                    idx_d   = idx_next;
                    cnt_d   = cnt_q + CNT_W'(1);
                    valid_d = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            data_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign data_out   = data_q;
    assign idx_out    = idx_q;
    assign valid      = valid_q;
    assign done       = done_q;
    assign step_count = cnt_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_stim_vector_sequencer.sv
// Self-checking bench for stim_vector_sequencer: directed vector tables, reset/abort,
// index wrap, zero-seed full period and a randomized run against a burst-level model.
module tb_stim_vector_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // dut_a: NUM_STEPS=4; dut_b: defaults; dut_z: zero seed, full LFSR period.
    logic a_start, a_stall, a_valid, a_busy, a_done;
    logic [14:0] a_data;
    logic [3:0]  a_idx;
    logic [4:0]  a_cnt;
    logic b_start, b_stall, b_valid, b_busy, b_done;
    logic [14:0] b_data;
    logic [3:0]  b_idx;
    logic [4:0]  b_cnt;
    logic z_start, z_stall, z_valid, z_busy, z_done;
    logic [14:0] z_data;
    logic [3:0]  z_idx;
    logic [15:0] z_cnt;

    stim_vector_sequencer #(.NUM_STEPS(4), .SEED(15'h0001)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .stall(a_stall), .data_out(a_data),
        .idx_out(a_idx), .valid(a_valid), .busy(a_busy), .done(a_done), .step_count(a_cnt)
    );
    stim_vector_sequencer dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .stall(b_stall), .data_out(b_data),
        .idx_out(b_idx), .valid(b_valid), .busy(b_busy), .done(b_done), .step_count(b_cnt)
    );
    stim_vector_sequencer #(.NUM_STEPS(32767), .SEED(15'h0000), .CNT_W(16)) dut_z (
        .clk(clk), .rst_n(rst_n), .start(z_start), .stall(z_stall), .data_out(z_data),
        .idx_out(z_idx), .valid(z_valid), .busy(z_busy), .done(z_done), .step_count(z_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input bit ok, input string name, input string detail);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    function automatic logic [14:0] lfsr_step(input logic [14:0] v);
        return (v >> 1) ^ (v[0] ? 15'h6000 : 15'h0000);
    endfunction

    typedef struct {
        logic        start;
        logic        stall;
        logic        v;
        logic [14:0] d;
        logic [3:0]  i;
        logic        dn;
        logic        b;
        logic [4:0]  c;
    } row_t;

    row_t tbl[$];

    function automatic row_t mk(input logic st, input logic sl, input logic v,
                                input logic [14:0] d, input logic [3:0] i, input logic dn,
                                input logic b, input logic [4:0] c);
        row_t r;
        r.start = st; r.stall = sl; r.v = v; r.d = d; r.i = i; r.dn = dn; r.b = b; r.c = c;
        return r;
    endfunction

    // Row k: inputs driven during cycle k, outputs expected during cycle k.
    task automatic run_table(input string name);
        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            check(a_valid == tbl[k].v && a_data == tbl[k].d && a_idx == tbl[k].i &&
                  a_done == tbl[k].dn && a_busy == tbl[k].b && a_cnt == tbl[k].c, name,
                  $sformatf("cyc %0d got v=%b d=%h i=%0d dn=%b b=%b c=%0d want v=%b d=%h i=%0d dn=%b b=%b c=%0d",
                            k, a_valid, a_data, a_idx, a_done, a_busy, a_cnt,
                            tbl[k].v, tbl[k].d, tbl[k].i, tbl[k].dn, tbl[k].b, tbl[k].c));
            a_start = tbl[k].start;
            a_stall = tbl[k].stall;
        end
        @(negedge clk);
        a_start = 1'b0;
        a_stall = 1'b0;
        tbl.delete();
    endtask

    task automatic do_reset();
        a_start = 0; a_stall = 0; b_start = 0; b_stall = 0; z_start = 0; z_stall = 0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [14:0] vec[0:31];

    initial begin
        bit          ok;
        int          nv;
        int          vcnt;
        int          m_n;
        bit          m_busy, m_valid, m_done;
        logic [14:0] exp_d;
        logic [3:0]  exp_i;
        logic [14:0] first2[0:1];

        vec[0] = 15'h0001;
        for (int k = 1; k < 32; k++) vec[k] = lfsr_step(vec[k-1]);

        a_start = 0; a_stall = 0; b_start = 0; b_stall = 0; z_start = 0; z_stall = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check(a_data == 0 && a_idx == 0 && !a_valid && !a_done && !a_busy && a_cnt == 0,
              "reset_a", $sformatf("got d=%h i=%0d v=%b dn=%b b=%b c=%0d want all 0",
                                   a_data, a_idx, a_valid, a_done, a_busy, a_cnt));
        check(b_data == 0 && !b_valid && !b_busy && z_data == 0 && !z_busy && z_cnt == 0,
              "reset_bz", $sformatf("got b_d=%h b_v=%b b_b=%b z_d=%h z_b=%b z_c=%0d want all 0",
                                    b_data, b_valid, b_busy, z_data, z_busy, z_cnt));
        @(negedge clk);
        rst_n = 1'b1;

        // Basic burst
        tbl.push_back(mk(1, 0, 0, 15'h0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 15'h0001, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 15'h6000, 1, 0, 1, 2));
        tbl.push_back(mk(0, 0, 1, 15'h3000, 2, 0, 1, 3));
        tbl.push_back(mk(0, 0, 1, 15'h1800, 3, 0, 1, 4));
        tbl.push_back(mk(0, 0, 0, 15'h1800, 3, 1, 1, 4));
        tbl.push_back(mk(0, 0, 0, 15'h1800, 3, 0, 0, 4));
        tbl.push_back(mk(0, 0, 0, 15'h1800, 3, 0, 0, 4));
        run_table("basic");

        // Stall during cycles 2..4
        do_reset();
        tbl.push_back(mk(1, 0, 0, 15'h0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 15'h0001, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 1, 15'h6000, 1, 0, 1, 2));
        tbl.push_back(mk(0, 1, 0, 15'h6000, 1, 0, 1, 2));
        tbl.push_back(mk(0, 1, 0, 15'h6000, 1, 0, 1, 2));
        tbl.push_back(mk(0, 0, 0, 15'h6000, 1, 0, 1, 2));
        tbl.push_back(mk(0, 0, 1, 15'h3000, 2, 0, 1, 3));
        tbl.push_back(mk(0, 0, 1, 15'h1800, 3, 0, 1, 4));
        tbl.push_back(mk(0, 0, 0, 15'h1800, 3, 1, 1, 4));
        tbl.push_back(mk(0, 0, 0, 15'h1800, 3, 0, 0, 4));
        run_table("stall");

        // Start while busy and in the DONE cycle is ignored
        do_reset();
        tbl.push_back(mk(1, 0, 0, 15'h0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 15'h0001, 0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 1, 15'h6000, 1, 0, 1, 2));
        tbl.push_back(mk(0, 0, 1, 15'h3000, 2, 0, 1, 3));
        tbl.push_back(mk(0, 0, 1, 15'h1800, 3, 0, 1, 4));
        tbl.push_back(mk(1, 0, 0, 15'h1800, 3, 1, 1, 4));
        tbl.push_back(mk(0, 0, 0, 15'h1800, 3, 0, 0, 4));
        tbl.push_back(mk(0, 0, 0, 15'h1800, 3, 0, 0, 4));
        run_table("start_busy");

        // Asynchronous reset mid-burst
        do_reset();
        @(negedge clk); a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        check(a_valid && a_data == 15'h3000 && a_idx == 2, "pre_abort",
              $sformatf("got v=%b d=%h i=%0d want v=1 d=3000 i=2", a_valid, a_data, a_idx));
        #1 rst_n = 1'b0;
        #1;
        check(a_data == 0 && a_idx == 0 && !a_valid && !a_done && !a_busy && a_cnt == 0,
              "abort_zero", $sformatf("got d=%h i=%0d v=%b dn=%b b=%b c=%0d want all 0",
                                      a_data, a_idx, a_valid, a_done, a_busy, a_cnt));
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
        ok = 1;
        repeat (5) begin
            @(negedge clk);
            if (a_done || a_busy || a_valid) ok = 0;
        end
        check(ok, "abort_no_done", "done/busy/valid seen after aborted burst, want none");
        a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        check(a_valid && a_data == 15'h0001 && a_idx == 0 && a_cnt == 1, "replay",
              $sformatf("got v=%b d=%h i=%0d c=%0d want v=1 d=0001 i=0 c=1",
                        a_valid, a_data, a_idx, a_cnt));
        repeat (8) @(negedge clk);

        // Index wrap with 16 steps
        do_reset();
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        ok = 1; nv = 0;
        for (int g = 0; g < 100 && b_busy; g++) begin
            if (b_valid) begin
                if (nv >= 16 || b_idx != 4'(nv % 14) || b_data != vec[nv]) ok = 0;
                nv++;
            end
            @(negedge clk);
        end
        check(ok, "wrap_seq", "idx/data sequence differs from 0..13,0,1 with LFSR data");
        check(nv == 16, "wrap_count", $sformatf("got %0d valid cycles want 16", nv));
        check(!b_busy, "wrap_term", "burst did not terminate within 100 cycles");
        check(b_cnt == 16, "wrap_cnt", $sformatf("got step_count %0d want 16", b_cnt));

        // Randomized start/stall against a burst-level model
        do_reset();
        m_n = 0; m_busy = 0; m_valid = 0; m_done = 0; vcnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            exp_d = (m_n == 0) ? 15'h0000 : vec[m_n-1];
            exp_i = (m_n == 0) ? 4'd0 : 4'((m_n - 1) % 14);
            check(b_valid == m_valid && b_data == exp_d && b_idx == exp_i && b_done == m_done &&
                  b_busy == m_busy && b_cnt == 5'(m_n), "random",
                  $sformatf("cyc %0d got v=%b d=%h i=%0d dn=%b b=%b c=%0d want v=%b d=%h i=%0d dn=%b b=%b c=%0d",
                            cyc, b_valid, b_data, b_idx, b_done, b_busy, b_cnt,
                            m_valid, exp_d, exp_i, m_done, m_busy, m_n));
            if (b_valid) vcnt++;
            if (b_done) begin
                check(vcnt == 16, "random_vcount",
                      $sformatf("got %0d valid cycles in burst want 16", vcnt));
                vcnt = 0;
            end
            b_start = ($urandom_range(3) == 0);
            b_stall = ($urandom_range(2) == 0);
            if (m_done) begin
                m_done = 0; m_busy = 0;
            end else if (!m_busy) begin
                if (b_start) begin m_busy = 1; m_n = 1; m_valid = 1; end
            end else if (b_stall) begin
                m_valid = 0;
            end else if (m_n == 16) begin
                m_valid = 0; m_done = 1;
            end else begin
                m_n++; m_valid = 1;
            end
        end
        b_start = 0; b_stall = 0;

        // Zero seed: full 2^15-1 period, never zero
        do_reset();
        @(negedge clk); z_start = 1'b1;
        @(negedge clk); z_start = 1'b0;
        ok = 1; nv = 0; exp_d = 15'h0001; first2[0] = '0; first2[1] = '0;
        for (int g = 0; g < 33000 && z_busy; g++) begin
            if (z_valid) begin
                if (nv < 2) first2[nv] = z_data;
                if (z_data == 0 || z_data != exp_d) ok = 0;
                exp_d = lfsr_step(exp_d);
                nv++;
            end
            @(negedge clk);
        end
        check(first2[0] == 15'h0001 && first2[1] == 15'h6000, "zero_seed_first",
              $sformatf("got %h,%h want 0001,6000", first2[0], first2[1]));
        check(ok, "zero_seed_period", "LFSR sequence hit zero or deviated");
        check(nv == 32767 && !z_busy && z_cnt == 16'd32767, "zero_seed_count",
              $sformatf("got %0d valid, busy=%b cnt=%0d want 32767, 0, 32767", nv, z_busy, z_cnt));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
